// File: rtl/timer_dev_pkg.sv
// Shared register map, CTRL field positions, mode codes and FSM states
// for the memory-mapped down-counter timer.
package timer_dev_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// Programmable down-counter timer on the device bus; irq feeds HWInt[0].
// Register file, control FSM and combinational read mux in one block.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_pend;
  state_e           state;

  logic wr_ctrl;
  logic wr_preset;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  // Bus clear of irq_pend is ordered before the FSM so an INT set wins;
  // the bus CTRL write is ordered after the FSM so a written EN wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      mode     <= MODE_ONESHOT;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_pend <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      if (wr_ctrl || wr_preset) irq_pend <= 1'b0;
      if (wr_preset) preset <= din[CNT_W-1:0];

      case (state)
        ST_IDLE: if (en) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= en ? ST_CNT : ST_IDLE;
        end
        ST_CNT: begin
          if (!en)               state <= ST_IDLE;
          else if (count != '0)  count <= count - CNT_W'(1);
          else                   state <= ST_INT;
        end
        ST_INT: begin
          irq_pend <= 1'b1;
          if (mode == MODE_RELOAD) begin
            state <= ST_LOAD;
          end else begin
            en    <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_ctrl) begin
        en   <= din[CTRL_EN];
        mode <= din[CTRL_MODE_HI:CTRL_MODE_LO];
        im   <= din[CTRL_IM];
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = {28'b0, im, mode, en};
      ADDR_PRESET: dout = 32'(preset);
      ADDR_COUNT:  dout = 32'(count);
      default:     dout = '0;
    endcase
  end

  assign irq = im & irq_pend;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: randomized scenarios compared against
// a timeline model (edge offsets from the enabling CTRL write).
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_dev #(.CNT_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Timeline model: k = edges after the enabling write edge E0.
  function automatic int exp_count_oneshot(input int n, input int k);
    return (n - (k - 2) > 0) ? n - (k - 2) : 0;
  endfunction

  function automatic int exp_count_reload(input int n, input int k);
    int r;
    r = (k - 2) % (n + 3);
    return (r <= n) ? n - r : 0;
  endfunction

  function automatic bit exp_pend(input int n, input int k);
    return k >= n + 4;
  endfunction

  // Called at a negedge; the following posedge is the write edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; we = 1'b0; addr = 2'd0; din = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++; $display("FAIL reset_read addr=%0d got %h exp 0", a, v);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end

    // Reload with PRESET=5: at k=10 COUNT reloaded to 5 and irq pending.
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'hB);
    tick(10);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL midcount_count got %0d exp 5", v); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL midcount_irq got %b exp 1", irq); end

    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq got %b exp 0", irq); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++; $display("FAIL async_reset_read addr=%0d got %h exp 0", a, v);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL post_reset_irq got %b exp 0", irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    int ns[4];
    ns[0] = 3; ns[1] = 0; ns[2] = $urandom_range(1, 15); ns[3] = $urandom_range(16, 30);
    foreach (ns[t]) begin
      int n;
      n = ns[t];
      bus_write(2'd1, 32'(n));
      bus_write(2'd0, 32'h9);
      for (int k = 1; k <= n + 7; k++) begin
        tick(1);
        if (k >= 2) begin
          rd(2'd2, v);
          n_checks++;
          if (v !== 32'(exp_count_oneshot(n, k))) begin
            n_fail++;
            $display("FAIL oneshot_count n=%0d k=%0d got %0d exp %0d", n, k, v, exp_count_oneshot(n, k));
          end
        end
        n_checks++;
        if (irq !== exp_pend(n, k)) begin
          n_fail++; $display("FAIL oneshot_irq n=%0d k=%0d got %b exp %b", n, k, irq, exp_pend(n, k));
        end
        rd(2'd0, v);
        n_checks++;
        if (v !== (exp_pend(n, k) ? 32'h8 : 32'h9)) begin
          n_fail++; $display("FAIL oneshot_ctrl n=%0d k=%0d got %h", n, k, v);
        end
      end
      bus_write(2'd0, 32'h0);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear n=%0d got %b exp 0", n, irq); end
      tick(2);
    end
  endtask

  task automatic test_reload();
    logic [31:0] v;
    int n, kend, waited;
    n = $urandom_range(0, 5);
    bus_write(2'd1, 32'(n));
    bus_write(2'd0, 32'hB);
    kend = n + 4 + 2 * (n + 3);
    for (int k = 1; k <= kend; k++) begin
      tick(1);
      if (k >= 2) begin
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'(exp_count_reload(n, k))) begin
          n_fail++;
          $display("FAIL reload_count n=%0d k=%0d got %0d exp %0d", n, k, v, exp_count_reload(n, k));
        end
      end
      n_checks++;
      if (irq !== exp_pend(n, k)) begin
        n_fail++; $display("FAIL reload_irq n=%0d k=%0d got %b exp %b", n, k, irq, exp_pend(n, k));
      end
    end
    // kend is an INT edge; clear right after each rise and time the next one.
    for (int i = 0; i < 3; i++) begin
      bus_write(2'd1, 32'(n));
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reload_bus_clear i=%0d got %b exp 0", i, irq); end
      waited = 0;
      while (irq !== 1'b1 && waited < 40) begin
        tick(1);
        waited++;
      end
      n_checks++;
      if (waited !== n + 2) begin
        n_fail++; $display("FAIL reload_period n=%0d i=%0d got %0d exp %0d edges", n, i, waited + 1, n + 3);
      end
    end
    bus_write(2'd0, 32'h0);
    tick(4);
  endtask

  task automatic test_mask();
    logic [31:0] v;
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq k=%0d got %b exp 0", k, irq); end
    end
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL mask_ctrl got %h exp 0", v); end
    bus_write(2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_unmask_cleared k=%0d got %b exp 0", k, irq); end
      tick(1);
    end
    bus_write(2'd0, 32'h0);
    tick(2);
  endtask

  task automatic test_pause();
    logic [31:0] v;
    int n, c, w;
    n = $urandom_range(8, 30);
    c = $urandom_range(2, n - 2);
    w = n + 2 - c;
    bus_write(2'd1, 32'(n));
    bus_write(2'd0, 32'h1);
    tick(w - 1);
    bus_write(2'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      rd(2'd2, v);
      n_checks++;
      if (v !== 32'(c)) begin n_fail++; $display("FAIL pause_frozen k=%0d got %0d exp %0d", k, v, c); end
      tick(1);
    end
    bus_write(2'd0, 32'h1);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'(c)) begin n_fail++; $display("FAIL restart_r0 got %0d exp %0d", v, c); end
    tick(2);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'(n)) begin n_fail++; $display("FAIL restart_reload got %0d exp %0d", v, n); end
    tick(1);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'(n - 1)) begin n_fail++; $display("FAIL restart_dec got %0d exp %0d", v, n - 1); end
    bus_write(2'd0, 32'h0);
    tick(4);
  endtask

  task automatic test_collision();
    logic [31:0] v;
    int n, m, n2;
    n = $urandom_range(1, 4);
    m = $urandom_range(5, 12);
    bus_write(2'd1, 32'(n));
    bus_write(2'd0, 32'hB);
    tick(n + 3);
    bus_write(2'd1, 32'(m));
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL collide_set_wins got %b exp 1", irq); end
    tick(1);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'(m)) begin n_fail++; $display("FAIL collide_new_preset got %0d exp %0d", v, m); end
    tick(1);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'(m - 1)) begin n_fail++; $display("FAIL collide_dec got %0d exp %0d", v, m - 1); end
    bus_write(2'd0, 32'h0);
    tick(4);

    // One-shot INT edge coincides with a CTRL write re-setting EN.
    n2 = $urandom_range(0, 4);
    bus_write(2'd1, 32'(n2));
    bus_write(2'd0, 32'h9);
    tick(n2 + 3);
    bus_write(2'd0, 32'h9);
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'h9) begin n_fail++; $display("FAIL collide_en_wins got %h exp 9", v); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL collide_ctrl_set_wins got %b exp 1", irq); end
    tick(2);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'(n2)) begin n_fail++; $display("FAIL collide_rerun_load got %0d exp %0d", v, n2); end
    bus_write(2'd0, 32'h0);
    tick(4);
  endtask

  task automatic test_regmap();
    logic [31:0] v, r;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h1);
    tick(6);
    r = $urandom();
    bus_write(2'd2, r);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL count_readonly got %h exp 0", v); end
    bus_write(2'd0, 32'hFFFF_FFF6);
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'h6) begin n_fail++; $display("FAIL ctrl_reserved got %h exp 6", v); end
    r = $urandom();
    bus_write(2'd1, r);
    bus_write(2'd3, ~r);
    rd(2'd1, v);
    n_checks++;
    if (v !== r) begin n_fail++; $display("FAIL preset_rw got %h exp %h", v, r); end
    rd(2'd3, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL addr3_read got %h exp 0", v); end
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'h6) begin n_fail++; $display("FAIL addr3_write_ignored got %h exp 6", v); end

    // MODE=2'b10 behaves as one-shot: EN drops after the interrupt.
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'hD);
    tick(6);
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'hC) begin n_fail++; $display("FAIL mode10_oneshot got %h exp c", v); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL mode10_irq got %b exp 1", irq); end
    bus_write(2'd0, 32'h0);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_mask();
    test_pause();
    test_collision();
    test_regmap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped programmable down-counter timer.
- Acts as the interrupt source for the coprocessor-0 interrupt logic: the `irq` output drives one bit of the 6-bit hardware-interrupt vector (HWInt[0]).
- The CPU programs it with sw/lw on the device bus. It generates an interrupt after PRESET+4 clock edges, in one-shot or auto-reload mode.
- The interrupt request stays pending until software rewrites a register, which the handler does before eret.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers (≤32; read data zero-extended to 32).

Ports:
- clk    input   1   system clock, all state updates on rising edge
- rst    input   1   asynchronous, active-high reset
- addr   input   2   word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we     input   1   write strobe, single-cycle, sampled on rising edge
- din    input   32  write data
- dout   output  32  combinational read data for addr
- irq    output  1   interrupt request, level, to HWInt[0]

Behaviour:
- Register map:
  - CTRL = {28'b0, IM[3], MODE[2:1], EN[0]}. Reserved bits are written as ignored and read as 0.
  - PRESET is read/write.
  - COUNT is read-only.
  - addr 3 reads 0; writes to COUNT or addr 3 are ignored.
- MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as one-shot.
- Reset (async): CTRL=0, PRESET=0, COUNT=0, irq_pend=0, state=IDLE, irq=0. Reset mid-count aborts immediately, with no pending irq.
- irq = IM & irq_pend (combinational). Clearing IM masks irq but keeps irq_pend.
- State machine (state encoding IDLE, LOAD, CNT, INT):
  - IDLE: if EN → LOAD, else stay. COUNT holds.
  - LOAD: COUNT <= PRESET. If EN → CNT, else → IDLE.
  - CNT: if !EN → IDLE (COUNT frozen). Else if COUNT≠0, COUNT <= COUNT−1 and stay. Else (COUNT==0) → INT.
  - INT: irq_pend <= 1.
    - One-shot: EN <= 0, → IDLE.
    - Auto-reload: → LOAD (EN stays 1).
- Latency: for a CTRL write setting EN at edge E0 with PRESET=N, irq_pend rises at edge E0+N+4. Auto-reload period is N+3 edges (INT→LOAD→CNT…).
- PRESET=0: valid; irq_pend rises at E0+4.
- Writes to PRESET during CNT do not affect the running COUNT. They take effect at the next LOAD.
- irq_pend is cleared by any write to CTRL or PRESET.
- Simultaneous events:
  - INT set and bus clear in the same cycle: set wins (no lost interrupt).
  - One-shot INT clearing EN in the same cycle as a CTRL write: the bus-written EN wins.
- Writing EN=0 then EN=1 restarts from LOAD: the count restarts from PRESET and does not resume.
- COUNT never wraps; decrement occurs only when COUNT≠0.

Decomposition:
- Shared package holds:
  - register offset constants (CTRL=0, PRESET=1, COUNT=2)
  - CTRL bit positions (EN, MODE, IM)
  - mode codes (ONESHOT=2'b00, RELOAD=2'b01)
  - state encoding (IDLE, LOAD, CNT, INT)
- No sub-module needed. The single block contains the register file, the FSM and the read mux.

Test Plan:
- Reset: assert rst mid-count with COUNT=5 and irq=1 → all registers 0, irq=0 immediately (async), dout=0 for every addr.
- One-shot: PRESET=3, CTRL=4'b1001 written at E0 → COUNT reads 3,2,1,0 at E2..E5. irq=1 after E7 and stays high; CTRL.EN reads 0. A write CTRL=0 → irq=0 next edge.
- Auto-reload: PRESET=2, CTRL=4'b1011 → irq_pend rises at E6, COUNT reloads to 2. Clearing with a PRESET write each time gives irq re-asserting every 5 edges.
- Masking: CTRL=4'b0001, PRESET=1 → irq stays 0 while irq_pend=1. A write to CTRL with IM=1 clears irq_pend, so irq remains 0, which verifies that a bus clear of pending is honoured.
- Pause/restart: PRESET=10, enable, at COUNT=6 write EN=0 → COUNT frozen at 6, state IDLE. Writing EN=1 → COUNT reloads to 10.
- Collision: bus write to PRESET in the same cycle the FSM is in INT → irq_pend=1 after the edge (set wins), and the new PRESET is used at the next LOAD in reload mode.
